// File: rtl/sparse_cluster_compressor.sv
// Sparse operand transmit encoder: emits a per-cluster nonzero bitmask beat, then the
// nonzero clusters packed TRANSFER_SIZE per block. Optional counters: SPARSE_COMPRESSOR_STATS_EN.

module sparse_cluster_slot #(
    parameter int COMPRESSION_WINDOW_SIZE = 8,
    parameter int CLUSTER_BITWIDTH        = 16
) (
    input  logic [COMPRESSION_WINDOW_SIZE-1:0]                       avail,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0][CLUSTER_BITWIDTH-1:0] clusters,
    output logic [COMPRESSION_WINDOW_SIZE-1:0]                       pick,
    output logic [COMPRESSION_WINDOW_SIZE-1:0]                       remain,
    output logic [CLUSTER_BITWIDTH-1:0]                              data
);
    // Isolate the lowest set bit; later slots see what is left.
    assign pick   = avail & (~avail + COMPRESSION_WINDOW_SIZE'(1));
    assign remain = avail & ~pick;

    always_comb begin
        data = '0;
        for (int i = 0; i < COMPRESSION_WINDOW_SIZE; i++)
            if (pick[i]) data = data | clusters[i];
    end
endmodule

module sparse_cluster_compressor #(
    parameter int TRANSFER_SIZE           = 2,
    parameter int CLUSTER_BITWIDTH        = 16,
    parameter int COMPRESSION_WINDOW_SIZE = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [COMPRESSION_WINDOW_SIZE*CLUSTER_BITWIDTH-1:0] inWindow,
    input  logic                                          inLast,
    input  logic                                          inValid,
    output logic                                          inReady,
    output logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0]     outData,
    output logic                                          outIsBitmask,
    output logic                                          outLast,
    output logic                                          outValid,
    input  logic                                          outReady
`ifdef SPARSE_COMPRESSOR_STATS_EN
    ,
    output logic [31:0]                                   statZeroClusters,
    output logic [31:0]                                   statDataBeats
`endif
);
    localparam int CWS   = COMPRESSION_WINDOW_SIZE;
    localparam int CB    = CLUSTER_BITWIDTH;
    localparam int TS    = TRANSFER_SIZE;
    localparam int CNT_W = $clog2(CWS + 1);

    generate
        if (CWS > TS * CB) begin : gBadConfig
            $error("bitmask does not fit in one transfer block");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EMIT_MASK, EMIT_DATA} state_t;
    state_t state, stateNext;

    function automatic logic [CNT_W-1:0] popCount(input logic [CWS-1:0] m);
        popCount = '0;
        for (int i = 0; i < CWS; i++) popCount = popCount + CNT_W'(m[i]);
    endfunction

    logic [CWS-1:0][CB-1:0] inClusters, clusters;
    logic [CWS-1:0]         inMask, remMask;
    logic                   lastReg, accept, dataFire;

    assign inClusters = inWindow;

    always_comb begin
        inMask = '0;
        for (int i = 0; i < CWS; i++) inMask[i] = |inClusters[i];
    end

    // Chain of slot selectors: slot k takes the k-th lowest remaining cluster.
    logic [TS:0][CWS-1:0]  slotAvail;
    logic [TS-1:0][CWS-1:0] slotPick;
    logic [TS-1:0][CB-1:0]  slotData;

    assign slotAvail[0] = remMask;

    generate
        for (genvar k = 0; k < TS; k++) begin : gSlot
            sparse_cluster_slot #(
                .COMPRESSION_WINDOW_SIZE(CWS),
                .CLUSTER_BITWIDTH       (CB)
            ) uSlot (
                .avail   (slotAvail[k]),
                .clusters(clusters),
                .pick    (slotPick[k]),
                .remain  (slotAvail[k+1]),
                .data    (slotData[k])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        inReady      = 1'b0;
        outValid     = 1'b0;
        outIsBitmask = 1'b0;
        outLast      = 1'b0;
        outData      = '0;
        accept       = 1'b0;
        dataFire     = 1'b0;
        case (state)
            IDLE: begin
                inReady = ~reset;
                if (inValid && !reset) begin
                    accept    = 1'b1;
                    stateNext = EMIT_MASK;
                end
            end
            EMIT_MASK: begin
                outValid          = 1'b1;
                outIsBitmask      = 1'b1;
                outData[CWS-1:0]  = remMask;
                outLast           = lastReg && (remMask == '0);
                if (outReady) stateNext = (remMask != '0) ? EMIT_DATA : IDLE;
            end
            EMIT_DATA: begin
                outValid = 1'b1;
                outData  = slotData;
                outLast  = lastReg && (int'(popCount(remMask)) <= TS);
                if (outReady) begin
                    dataFire = 1'b1;
                    if (slotAvail[TS] == '0) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clusters <= '0;
            remMask  <= '0;
            lastReg  <= 1'b0;
        end else if (accept) begin
            clusters <= inClusters;
            remMask  <= inMask;
            lastReg  <= inLast;
        end else if (dataFire) begin
            remMask  <= slotAvail[TS];
        end
    end

`ifdef SPARSE_COMPRESSOR_STATS_EN
    logic [32:0] zeroSum, beatSum;
    assign zeroSum = {1'b0, statZeroClusters} + 33'(CWS - int'(popCount(inMask)));
    assign beatSum = {1'b0, statDataBeats} + 33'd1;

    // Counters saturate rather than wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            statZeroClusters <= '0;
            statDataBeats    <= '0;
        end else begin
            if (accept)   statZeroClusters <= zeroSum[32] ? 32'hFFFF_FFFF : zeroSum[31:0];
            if (dataFire) statDataBeats    <= beatSum[32] ? 32'hFFFF_FFFF : beatSum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_sparse_cluster_compressor.sv
// Self-checking bench for sparse_cluster_compressor: directed scenarios plus randomized
// windows checked against a list-based packing model.

module tb_sparse_cluster_compressor;
    localparam int TS = 2, CB = 16, CWS = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic [127:0]   inWindow;
    logic           inLast, inValid, inReady;
    logic [31:0]    outData;
    logic           outIsBitmask, outLast, outValid, outReady;
`ifdef SPARSE_COMPRESSOR_STATS_EN
    logic [31:0]    statZeroClusters, statDataBeats;
`endif

    always #5 clock = ~clock;

    sparse_cluster_compressor #(
        .TRANSFER_SIZE(TS), .CLUSTER_BITWIDTH(CB), .COMPRESSION_WINDOW_SIZE(CWS)
    ) dut (
        .clock(clock), .reset(reset), .inWindow(inWindow), .inLast(inLast),
        .inValid(inValid), .inReady(inReady), .outData(outData),
        .outIsBitmask(outIsBitmask), .outLast(outLast), .outValid(outValid),
        .outReady(outReady)
`ifdef SPARSE_COMPRESSOR_STATS_EN
        , .statZeroClusters(statZeroClusters), .statDataBeats(statDataBeats)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        isMask;
        logic        last;
    } beat_t;

    beat_t expQ[$];
    beat_t gotQ[$];
    int checks = 0, failures = 0;
    int lastCycles;

    localparam logic [127:0] SCEN1 = {16'h7777, 16'h6666, 16'h5555, 16'h0000,
                                      16'h0000, 16'h2222, 16'h1111, 16'h0000};

    function automatic logic [127:0] denseWindow();
        logic [127:0] w;
        for (int i = 0; i < CWS; i++) w[i*16 +: 16] = 16'(16'h0101 * (i + 1));
        return w;
    endfunction

    // Model: list the nonzero clusters in order, then chop the list into pairs.
    task automatic buildExpected(input logic [127:0] win, input logic last);
        logic [15:0] nz[$];
        logic [31:0] m, d;
        int nBeats;
        expQ.delete();
        m = '0;
        for (int i = 0; i < CWS; i++)
            if (win[i*16 +: 16] != 16'h0) begin
                nz.push_back(win[i*16 +: 16]);
                m[i] = 1'b1;
            end
        nBeats = (nz.size() + TS - 1) / TS;
        expQ.push_back('{data: m, isMask: 1'b1, last: last && (nz.size() == 0)});
        for (int b = 0; b < nBeats; b++) begin
            d = '0;
            for (int s = 0; s < TS; s++)
                if (b*TS + s < nz.size()) d[s*16 +: 16] = nz[b*TS + s];
            expQ.push_back('{data: d, isMask: 1'b0, last: last && (b == nBeats - 1)});
        end
    endtask

    task automatic runWindow(input logic [127:0] win, input logic last,
                             input int stallPct, input string tag);
        beat_t e, got, prev;
        int cycles;
        logic prevStall;
        buildExpected(win, last);
        gotQ.delete();
        @(negedge clock);
        outReady = 1'b1;
        inWindow = win; inLast = last; inValid = 1'b1;
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("FAIL %s inReady before accept: got %b want 1", tag, inReady);
        end
        @(posedge clock);
        #1 inValid = 1'b0;
        cycles = 0;
        prevStall = 1'b0;
        prev = '0;
        while (expQ.size() > 0 && cycles < 200) begin
            @(negedge clock);
            cycles++;
            outReady = ($urandom_range(99) >= stallPct);
            got = '{data: outData, isMask: outIsBitmask, last: outLast};
            checks++;
            if (outValid !== 1'b1) begin
                failures++;
                $display("FAIL %s outValid gap cycle %0d: got %b want 1", tag, cycles, outValid);
            end
            if (prevStall) begin
                checks++;
                if (got !== prev) begin
                    failures++;
                    $display("FAIL %s stall hold: got %h/%b/%b want %h/%b/%b", tag,
                             got.data, got.isMask, got.last, prev.data, prev.isMask, prev.last);
                end
            end
            if (outValid === 1'b1 && outReady) begin
                e = expQ.pop_front();
                gotQ.push_back(got);
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s beat %0d: got %h/%b/%b want %h/%b/%b", tag, gotQ.size() - 1,
                             got.data, got.isMask, got.last, e.data, e.isMask, e.last);
                end
                prevStall = 1'b0;
            end else begin
                prevStall = (outValid === 1'b1);
                prev = got;
            end
        end
        if (expQ.size() > 0) begin
            checks++; failures++;
            $display("FAIL %s timeout: %0d beats missing", tag, expQ.size());
            expQ.delete();
        end
        lastCycles = cycles;
        @(negedge clock);
        outReady = 1'b1;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle after window: got inReady=%b outValid=%b want 1/0",
                     tag, inReady, outValid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1; inWindow = '0; inLast = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({outValid, outIsBitmask, outLast, inReady} !== 4'b0 || outData !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got v=%b m=%b l=%b r=%b d=%h want all 0",
                     outValid, outIsBitmask, outLast, inReady, outData);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got inReady=%b outValid=%b want 1/0", inReady, outValid);
        end
    endtask

    task automatic test_scenario1();
        runWindow(SCEN1, 1'b0, 0, "scen1");
        checks++;
        if (lastCycles !== 4) begin
            failures++;
            $display("FAIL scen1_cycles: got %0d want 4", lastCycles);
        end
        checks++;
        if (gotQ.size() != 4 || gotQ[0].data !== 32'h000000E6 || gotQ[0].isMask !== 1'b1 ||
            gotQ[1].data !== 32'h22221111 || gotQ[2].data !== 32'h66665555 ||
            gotQ[3].data !== 32'h00007777) begin
            failures++;
            $display("FAIL scen1_literal: got %0d beats, want E6,22221111,66665555,00007777",
                     gotQ.size());
        end
    endtask

    task automatic test_all_zero();
        runWindow('0, 1'b1, 0, "zero");
        checks++;
        if (gotQ.size() != 1 || gotQ[0] !== '{data: 32'h0, isMask: 1'b1, last: 1'b1}) begin
            failures++;
            $display("FAIL zero_literal: got %0d beats, want one mask beat 0 with last", gotQ.size());
        end
    endtask

    task automatic test_dense();
        int nLast;
        runWindow(denseWindow(), 1'b1, 0, "dense");
        nLast = 0;
        foreach (gotQ[i]) nLast += int'(gotQ[i].last);
        checks++;
        if (gotQ.size() != 5 || gotQ[0].data !== 32'h000000FF || gotQ[1].data !== 32'h02020101 ||
            gotQ[2].data !== 32'h04040303 || gotQ[3].data !== 32'h06060505 ||
            gotQ[4].data !== 32'h08080707 || nLast != 1 || gotQ[4].last !== 1'b1) begin
            failures++;
            $display("FAIL dense_literal: got %0d beats, %0d last flags, want 5 beats, 1 last",
                     gotQ.size(), nLast);
        end
    endtask

    task automatic test_stall();
        logic [31:0] want[7];
        logic        rdy[7];
        want = '{32'hE6, 32'h22221111, 32'h22221111, 32'h22221111, 32'h22221111,
                 32'h66665555, 32'h00007777};
        rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clock);
        inWindow = SCEN1; inLast = 1'b0; inValid = 1'b1;
        @(posedge clock);
        #1 inValid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            outReady = rdy[c];
            checks++;
            if (outValid !== 1'b1 || outData !== want[c]) begin
                failures++;
                $display("FAIL stall cycle %0d: got v=%b d=%h want v=1 d=%h",
                         c, outValid, outData, want[c]);
            end
        end
        @(negedge clock);
        outReady = 1'b1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            failures++;
            $display("FAIL stall_end: got v=%b r=%b want 0/1 (beat duplicated?)", outValid, inReady);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] w;
        @(negedge clock);
        outReady = 1'b1;
        inWindow = SCEN1; inLast = 1'b0; inValid = 1'b1;
        @(posedge clock);
        #1 inValid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (outData !== 32'h66665555) begin
            failures++;
            $display("FAIL rstmid_pre: got %h want 66665555", outData);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || outData !== 32'h0 || inReady !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop: got v=%b d=%h r=%b want 0/0/0", outValid, outData, inReady);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_stale: got outValid=%b want 0", outValid);
        end
        w = '0;
        w[3*16 +: 16] = 16'h00AB;
        runWindow(w, 1'b0, 0, "rstmid");
        checks++;
        if (gotQ.size() != 2 || gotQ[0].data !== 32'h8 || gotQ[1].data !== 32'hAB) begin
            failures++;
            $display("FAIL rstmid_literal: got %0d beats, want 00000008 then 000000AB", gotQ.size());
        end
    endtask

    task automatic test_random();
        logic [127:0] w;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < CWS; i++)
                w[i*16 +: 16] = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom_range(65535, 1));
            runWindow(w, 1'($urandom_range(1)), (n % 2) ? 40 : 0, "random");
        end
    endtask

`ifdef SPARSE_COMPRESSOR_STATS_EN
    task automatic test_stats();
        test_reset();
        checks++;
        if (statZeroClusters !== 32'd0 || statDataBeats !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", statZeroClusters, statDataBeats);
        end
        runWindow(SCEN1, 1'b0, 0, "stats1");
        runWindow(denseWindow(), 1'b1, 0, "stats3");
        checks++;
        if (statZeroClusters !== 32'd3 || statDataBeats !== 32'd7) begin
            failures++;
            $display("FAIL stats_count: got %0d/%0d want 3/7", statZeroClusters, statDataBeats);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; inValid = 1'b0; inLast = 1'b0; inWindow = '0; outReady = 1'b1;
        test_reset();
        test_scenario1();
        test_all_zero();
        test_dense();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef SPARSE_COMPRESSOR_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sparse_cluster_compressor.md
# sparse_cluster_compressor

Transmit-side encoder for the sparse operand transfer protocol. Accepts one dense compression window of clusters and computes a per-cluster nonzero bitmask. Streams that bitmask as one beat, followed by the nonzero clusters packed TRANSFER_SIZE per transfer block. Sits upstream of the mask-accumulate/mask-filter/MAC-buffer-update decoding path, which consumes the bitmask and transfer blocks it emits.

## Interface
- TRANSFER_SIZE, 2, clusters per transfer block.
- CLUSTER_BITWIDTH, 16, bits per cluster.
- COMPRESSION_WINDOW_SIZE, 8, clusters per window; must be ≤ TRANSFER_SIZE*CLUSTER_BITWIDTH (elaboration-time check).

Ports:
- clock  in  1  sole clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- inWindow  in  COMPRESSION_WINDOW_SIZE*CLUSTER_BITWIDTH  dense window; cluster i at bits [i*CLUSTER_BITWIDTH +: CLUSTER_BITWIDTH].
- inLast  in  1  window is last of the stream.
- inValid  in  1  window present.
- inReady  out  1  block can accept a window.
- outData  out  TRANSFER_SIZE*CLUSTER_BITWIDTH  bitmask beat or transfer block.
- outIsBitmask  out  1  current beat carries the bitmask.
- outLast  out  1  final beat of a window flagged inLast.
- outValid  out  1  beat present.
- outReady  in  1  downstream accepts beat.

## Operation
- States: IDLE, EMIT_MASK, EMIT_DATA.
- IDLE:
  - inReady=1.
  - On inValid&inReady: register window and inLast.
  - Compute mask bit i = (cluster i != 0).
  - Load remaining-mask register with the mask.
  - Go to EMIT_MASK.
- EMIT_MASK:
  - outValid=1, outIsBitmask=1.
  - outData[COMPRESSION_WINDOW_SIZE-1:0]=mask; upper bits 0.
  - outLast = storedLast & (mask==0).
  - On outReady: go to EMIT_DATA if mask!=0, else IDLE.
- EMIT_DATA:
  - outValid=1, outIsBitmask=0.
  - Select up to TRANSFER_SIZE lowest set bits of the remaining mask, in ascending cluster index.
  - Slot k of outData = k-th selected cluster. Unfilled slots = 0.
  - outLast = storedLast & (remaining popcount ≤ TRANSFER_SIZE).
  - On outReady: clear the selected bits. Go to IDLE if remaining becomes 0, else stay.
- Data beats per window = ceil(popcount(mask)/TRANSFER_SIZE); popcount is clog2(COMPRESSION_WINDOW_SIZE+1) bits wide.
- Windows never share a transfer block; each window restarts packing at slot 0.

## Timing
- Reset values:
  - State IDLE.
  - outValid=0, outIsBitmask=0, outLast=0, outData=0.
  - inReady=0 while reset is asserted; inReady=1 from the first cycle after deassertion.
- Latency:
  - Window accepted at edge N → bitmask beat valid in cycle N+1.
  - With outReady held high, each beat occupies one cycle.
  - The window occupies 1+ceil(pop/TRANSFER_SIZE) cycles after acceptance. inReady returns in the cycle after the last beat handshake.
- Handshake:
  - Transfer occurs on a posedge where outValid&outReady.
  - While outValid&~outReady, outData/outIsBitmask/outLast hold stable.
  - outValid never drops without a handshake, except on reset.
  - inReady does not depend combinationally on outReady.
- Reset mid-window: the in-flight window is discarded, outValid drops immediately, and no partial beat is emitted after release.

## Configuration
- SPARSE_COMPRESSOR_STATS_EN defined:
  - Adds outputs statZeroClusters[31:0] and statDataBeats[31:0].
  - statZeroClusters counts zero clusters of accepted windows.
  - statDataBeats counts handshaken data beats.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
Parameters for all scenarios: TRANSFER_SIZE=2, CLUSTER_BITWIDTH=16, COMPRESSION_WINDOW_SIZE=8.

- Window {c0..c7}={0,0x1111,0x2222,0,0,0x5555,0x6666,0x7777}, outReady=1 → beats 0x000000E6 (isBitmask), 0x22221111, 0x66665555, 0x00007777; the window occupies 4 cycles after acceptance.
- All-zero window with inLast=1 → single beat 0x00000000, outIsBitmask=1, outLast=1; inReady=1 in the cycle after the handshake.
- Fully dense window c_i=0x0101*(i+1), inLast=1 → mask beat 0x000000FF, then 4 data beats 0x02020101, 0x04040303, 0x06060505, 0x08080707; outLast only on the final beat.
- Scenario 1 with outReady low for 3 cycles while 0x22221111 is presented → outData/outValid unchanged for all 3 cycles; no beat lost or duplicated.
- Reset asserted during the second data beat of scenario 1 → outValid=0 immediately; after release, a window with only c3=0x00AB yields 0x00000008 then 0x000000AB.
- With SPARSE_COMPRESSOR_STATS_EN, run scenarios 1 and 3 → statZeroClusters=3, statDataBeats=7.
